// File: rtl/bit_full_adder.sv
// bit_full_adder: single-bit full adder, the leaf cell of the ripple-carry chain.
// The combinational outputs depend only on a_i/b_i/carry_i, so they stay valid
// even if clk_i/rst_i are unconnected. A registered copy of the result is kept
// for pipelined users.
module bit_full_adder (
    input  logic clk_i,
    input  logic rst_i,
    input  logic a_i,
    input  logic b_i,
    input  logic carry_i,
    output logic sum_o,
    output logic carry_o,
    output logic sum_q_o,
    output logic carry_q_o
);

    logic sum_d,   sum_q;
    logic carry_d, carry_q;

    // Stateless sum/majority-carry logic: {carry, sum} = a + b + cin.
    always_comb begin
        sum_d   = a_i ^ b_i ^ carry_i;
        carry_d = (a_i & b_i) | (a_i & carry_i) | (b_i & carry_i);
    end

    assign sum_o   = sum_d;
    assign carry_o = carry_d;

    // Capture the result every rising edge; an async reset clears it immediately
    // and wins over a coincident clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum_q_o   = sum_q;
    assign carry_q_o = carry_q;

endmodule

// File: tb/tb_bit_full_adder.sv
// Bench for bit_full_adder: arithmetic reference model plus directed pins.
module tb_bit_full_adder;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, c = 1'b0;
    logic sum, carry, sum_q, carry_q;
    logic cmp_en = 1'b0;
    logic [1:0] model_q;
    int checks = 0;
    int failures = 0;

    bit_full_adder dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .a_i       (a),
        .b_i       (b),
        .carry_i   (c),
        .sum_o     (sum),
        .carry_o   (carry),
        .sum_q_o   (sum_q),
        .carry_q_o (carry_q)
    );

    // Clock only runs once enabled, so the first sweeps see no edges at all.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    function automatic logic [1:0] add3(input logic x, input logic y, input logic z);
        return 2'(x) + 2'(y) + 2'(z);
    endfunction

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference for the registered path: result of the inputs at the last edge,
    // zero whenever reset is or was asserted since.
    always @(posedge clk or posedge rst) begin
        if (rst) model_q <= 2'b00;
        else     model_q <= add3(a, b, c);
    end

    // Every clock, away from the active edge, compare both paths with the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("comb_cycle", {carry, sum}, add3(a, b, c));
            chk("reg_cycle", {carry_q, sum_q}, model_q);
        end
    end

    logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        logic [2:0] v;
        // Reset state with no clock.
        #1;
        chk("reset_state", {carry_q, sum_q}, 2'b00);

        // Exhaustive combinational sweep, no clock.
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a, b, c} = v;
            #5;
            chk("truth_table", {carry, sum}, tt[i]);
            chk("truth_arith", {carry, sum}, add3(a, b, c));
            #5;
        end

        // Random combinational sweep; any mismatch stops the run.
        for (int i = 0; i < 16; i++) begin
            {a, b, c} = 3'($urandom_range(0, 7));
            #5;
            checks++;
            if ({carry, sum} !== add3(a, b, c)) begin
                failures++;
                $display("FAIL random_comb: a=%b b=%b c=%b got %b expected %b",
                         a, b, c, {carry, sum}, add3(a, b, c));
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $fatal(1, "combinational mismatch");
            end
            #5;
        end

        // Start the clock, release reset away from any edge.
        clk_en = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        cmp_en = 1'b1;

        // Registered latency.
        @(negedge clk);
        {a, b, c} = 3'b101;
        @(posedge clk); #1;
        chk("lat_first", {carry_q, sum_q}, 2'b10);
        @(negedge clk);
        {a, b, c} = 3'b001;
        #1;
        chk("lat_hold", {carry_q, sum_q}, 2'b10);
        @(posedge clk); #1;
        chk("lat_next", {carry_q, sum_q}, 2'b01);

        // Asynchronous reset between edges.
        @(negedge clk);
        {a, b, c} = 3'b110;
        @(posedge clk); #1;
        chk("pre_reset_latch", {carry_q, sum_q}, 2'b10);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_clear", {carry_q, sum_q}, 2'b00);
        chk("comb_in_reset", {carry, sum}, 2'b10);
        @(posedge clk); #1;
        chk("reset_held", {carry_q, sum_q}, 2'b00);
        @(negedge clk);
        #2 rst = 1'b0;

        // Randomized clocked run checked by the compare process.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1 {a, b, c} = 3'($urandom_range(0, 7));
        end

        // Reset rising on the same timestep as a clock edge.
        @(negedge clk);
        {a, b, c} = 3'b111;
        @(posedge clk);
        rst = 1'b1;
        #1;
        chk("coincident_edge", {carry_q, sum_q}, 2'b00);

        // Release from reset.
        @(negedge clk);
        {a, b, c} = 3'b011;
        #2 rst = 1'b0;
        #1;
        chk("release_hold", {carry_q, sum_q}, 2'b00);
        @(posedge clk); #1;
        chk("release_first", {carry_q, sum_q}, 2'b10);

        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
